// File: rtl/interface_hcsr04_multi.sv
// interface_hcsr04_multi: round-robin scanner for N HC-SR04 sensors.
// One sensor active at a time; per-channel distance in cm or a timeout flag.
module interface_hcsr04_multi #(
  parameter int N_CANAIS       = 4,
  parameter int LARGURA        = 12,
  parameter int CICLOS_CM      = 2941,
  parameter int CICLOS_TRIGGER = 500,
  parameter int CICLOS_TIMEOUT = 1_500_000,
  parameter int CICLOS_GUARDA  = 3_000_000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          medir,
  input  logic                          modo,
  input  logic [N_CANAIS-1:0]           echo,
  output logic [N_CANAIS-1:0]           trigger,
  output logic [N_CANAIS*LARGURA-1:0]   medida,
  output logic [N_CANAIS-1:0]           timeout,
  output logic [2:0]                    canal,
  output logic                          ocupado,
  output logic                          pronto,
  output logic [3:0]                    db_estado
);

  localparam int MAXC = (CICLOS_TRIGGER > CICLOS_GUARDA) ?
                        CICLOS_TRIGGER : CICLOS_GUARDA;
  localparam int WC = $clog2(MAXC + 1);
  localparam int WS = $clog2(CICLOS_CM + 1);
  localparam int WT = $clog2(CICLOS_TIMEOUT + 1);

  localparam logic [WC-1:0] FIM_TRIG  = WC'(CICLOS_TRIGGER - 1);
  localparam logic [WC-1:0] FIM_GUAR  = WC'(CICLOS_GUARDA - 1);
  localparam logic [WS-1:0] FIM_CM    = WS'(CICLOS_CM - 1);
  localparam logic [WT-1:0] FIM_TO    = WT'(CICLOS_TIMEOUT - 1);
  // all-ones is reserved as the timeout marker
  localparam logic [LARGURA-1:0] CM_MAX = {{(LARGURA-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    TRIGGER  = 4'd2,
    ESPERA   = 4'd3,
    MEDINDO  = 4'd4,
    ARMAZENA = 4'd5,
    ESTOURO  = 4'd6,
    GUARDA   = 4'd7,
    FIM      = 4'd8
  } estado_t;

  estado_t estado, prox;

  logic [N_CANAIS-1:0] echo_m, echo_s, echo_d;
  logic [WC-1:0]       ciclos;
  logic [WS-1:0]       sub_cm;
  logic [WT-1:0]       cnt_to;
  logic [LARGURA-1:0]  cnt_cm;

  logic echo_sel, echo_ant;
  logic sobe, desce, estouro, ultimo;

  assign db_estado = estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_d <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_d <= echo_s;
    end
  end

  always_comb begin
    echo_sel = 1'b0;
    echo_ant = 1'b0;
    for (int k = 0; k < N_CANAIS; k++) begin
      if (canal == 3'(k)) begin
        echo_sel = echo_s[k];
        echo_ant = echo_d[k];
      end
    end
  end

  assign sobe    = echo_sel & ~echo_ant;
  assign desce   = ~echo_sel & echo_ant;
  assign estouro = (cnt_to == FIM_TO);
  assign ultimo  = (canal == 3'(N_CANAIS - 1));

  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL: if (medir || modo) prox = PREPARA;
      PREPARA: prox = TRIGGER;
      TRIGGER: if (ciclos == FIM_TRIG) prox = ESPERA;
      ESPERA: begin
        if (estouro)   prox = ESTOURO;
        else if (sobe) prox = MEDINDO;
      end
      MEDINDO: begin
        if (estouro)    prox = ESTOURO;
        else if (desce) prox = ARMAZENA;
      end
      ARMAZENA: prox = GUARDA;
      ESTOURO:  prox = GUARDA;
      GUARDA: begin
        if (ciclos == FIM_GUAR)
          prox = ultimo ? FIM : PREPARA;
      end
      FIM:     prox = modo ? PREPARA : INICIAL;
      default: prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= INICIAL;
      ciclos  <= '0;
      sub_cm  <= '0;
      cnt_to  <= '0;
      cnt_cm  <= '0;
      canal   <= '0;
      trigger <= '0;
      medida  <= '0;
      timeout <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      estado <= prox;

      if ((estado == TRIGGER || estado == GUARDA) && prox == estado)
        ciclos <= ciclos + 1'b1;
      else
        ciclos <= '0;

      if (estado == PREPARA) begin
        sub_cm <= '0;
        cnt_cm <= '0;
        cnt_to <= '0;
      end

      if (estado == ESPERA || estado == MEDINDO)
        cnt_to <= cnt_to + 1'b1;

      if (estado == MEDINDO) begin
        if (sub_cm == FIM_CM) begin
          sub_cm <= '0;
          if (cnt_cm != CM_MAX) cnt_cm <= cnt_cm + 1'b1;
        end else begin
          sub_cm <= sub_cm + 1'b1;
        end
      end

      for (int k = 0; k < N_CANAIS; k++) begin
        if (canal == 3'(k)) begin
          if (estado == ARMAZENA) begin
            medida[k*LARGURA +: LARGURA] <= cnt_cm;
            timeout[k] <= 1'b0;
          end else if (estado == ESTOURO) begin
            medida[k*LARGURA +: LARGURA] <= '1;
            timeout[k] <= 1'b1;
          end
        end
      end

      if (estado == GUARDA && prox == PREPARA)
        canal <= canal + 3'd1;
      else if (estado == FIM)
        canal <= '0;

      for (int k = 0; k < N_CANAIS; k++)
        trigger[k] <= (estado == TRIGGER) && (canal == 3'(k));

      ocupado <= (prox != INICIAL);
      pronto  <= (estado == FIM);
    end
  end

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Bench for interface_hcsr04_multi: sensor model driving echoes,
// results checked against a per-channel distance reference.
module tb_interface_hcsr04_multi;

  localparam int N   = 4;
  localparam int L   = 12;
  localparam int CM  = 10;
  localparam int TRG = 5;
  localparam int TO  = 1000;
  localparam int GRD = 20;

  logic           clock = 1'b0;
  logic           reset;
  logic           medir;
  logic           modo;
  logic [N-1:0]   echo;
  logic [N-1:0]   trigger;
  logic [N*L-1:0] medida;
  logic [N-1:0]   timeout;
  logic [2:0]     canal;
  logic           ocupado;
  logic           pronto;
  logic [3:0]     db_estado;

  int total = 0;
  int bad   = 0;

  int ws [N];
  int ds [N];
  bit st [N];
  int clr_at = -1;

  always #5 clock = ~clock;

  interface_hcsr04_multi #(
    .N_CANAIS(N),
    .LARGURA(L),
    .CICLOS_CM(CM),
    .CICLOS_TRIGGER(TRG),
    .CICLOS_TIMEOUT(TO),
    .CICLOS_GUARDA(GRD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .medir(medir),
    .modo(modo),
    .echo(echo),
    .trigger(trigger),
    .medida(medida),
    .timeout(timeout),
    .canal(canal),
    .ocupado(ocupado),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  // distance rule: truncated cm, saturating below the all-ones marker
  function automatic logic [L-1:0] ref_cm(input int w);
    int d;
    if (w <= 0) return '1;
    d = w / CM;
    if (d > (1 << L) - 2) d = (1 << L) - 2;
    return L'(d);
  endfunction

  task automatic randomize_scan();
    for (int k = 0; k < N; k++) begin
      ws[k] = int'($urandom_range(1, 300));
      ds[k] = int'($urandom_range(1, 10));
      st[k] = 1'b0;
    end
  endtask

  task automatic run_channel(input int k, input int w, input int d,
                             input bit stale, output int lat);
    logic [N-1:0] want;
    int n;
    int wid;
    want = '0;
    want[k] = 1'b1;
    if (stale) echo[k] = 1'b1;
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      n++;
      if (trigger != '0) break;
    end
    lat = n;
    total++;
    if (trigger !== want) begin
      bad++;
      $display("FAIL trig_sel ch%0d got %b want %b", k, trigger, want);
    end
    if (trigger == '0) return;
    wid = 0;
    while (trigger[k] === 1'b1 && wid < 50) begin
      total++;
      if (!$onehot0(trigger)) begin
        bad++;
        $display("FAIL trig_onehot ch%0d got %b", k, trigger);
      end
      wid++;
      @(negedge clock);
    end
    total++;
    if (wid != TRG) begin
      bad++;
      $display("FAIL trig_width ch%0d got %0d want %0d", k, wid, TRG);
    end
    if (stale) begin
      repeat (3) @(negedge clock);
      echo[k] = 1'b0;
      repeat (5) @(negedge clock);
    end else begin
      repeat (d) @(negedge clock);
    end
    if (w > 0) begin
      echo[k] = 1'b1;
      repeat (w) @(negedge clock);
      echo[k] = 1'b0;
    end
  endtask

  task automatic run_scan(input bit pulse_medir, input bit chk_lat);
    int lat;
    int n;
    logic [L-1:0] got;
    if (pulse_medir) begin
      @(negedge clock);
      medir = 1'b1;
      @(negedge clock);
      medir = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (k == clr_at) modo = 1'b0;
      run_channel(k, ws[k], ds[k], st[k], lat);
      if (k == 0 && chk_lat) begin
        total++;
        if (lat != 2) begin
          bad++;
          $display("FAIL trig_latency got %0d want 2", lat);
        end
      end
    end
    n = 0;
    while (pronto !== 1'b1 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (pronto !== 1'b1) begin
      bad++;
      $display("FAIL pronto_seen got %b want 1", pronto);
    end
    @(negedge clock);
    total++;
    if (pronto !== 1'b0) begin
      bad++;
      $display("FAIL pronto_width got %b want 0", pronto);
    end
    for (int k = 0; k < N; k++) begin
      got = medida[k*L +: L];
      total++;
      if (got !== ref_cm(ws[k])) begin
        bad++;
        $display("FAIL medida ch%0d w=%0d got %0d want %0d",
                 k, ws[k], got, ref_cm(ws[k]));
      end
      total++;
      if (timeout[k] !== (ws[k] <= 0)) begin
        bad++;
        $display("FAIL timeout ch%0d got %b want %b",
                 k, timeout[k], (ws[k] <= 0));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (db_estado !== 4'd0 || ocupado !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle got st=%0d oc=%b want st=0 oc=0",
               tag, db_estado, ocupado);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (trigger !== '0 || medida !== '0 || timeout !== '0 ||
        canal !== 3'd0 || ocupado !== 1'b0 || pronto !== 1'b0 ||
        db_estado !== 4'd0) begin
      bad++;
      $display("FAIL %s got trig=%b med=%h to=%b canal=%0d oc=%b pr=%b st=%0d want all 0",
               tag, trigger, medida, timeout, canal, ocupado, pronto, db_estado);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    medir = 1'b0;
    modo  = 1'b0;
    echo  = '0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_state");
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_idle("after_reset");
  endtask

  task automatic test_single_scan();
    ws[0] = 100; ws[1] = 250; ws[2] = 37; ws[3] = 9;
    for (int k = 0; k < N; k++) begin
      ds[k] = int'($urandom_range(1, 10));
      st[k] = 1'b0;
    end
    run_scan(1'b1, 1'b1);
    check_idle("single");
    randomize_scan();
    run_scan(1'b1, 1'b1);
    check_idle("single_rand");
  endtask

  task automatic test_timeout();
    randomize_scan();
    ws[2] = -1;
    run_scan(1'b1, 1'b0);
    randomize_scan();
    run_scan(1'b1, 1'b0);
  endtask

  task automatic test_stale();
    randomize_scan();
    ws[1] = 50;
    st[1] = 1'b1;
    run_scan(1'b1, 1'b0);
    st[1] = 1'b0;
  endtask

  task automatic test_continuous();
    int hits;
    @(negedge clock);
    modo = 1'b1;
    randomize_scan();
    run_scan(1'b0, 1'b0);
    randomize_scan();
    run_scan(1'b0, 1'b0);
    randomize_scan();
    clr_at = 2;
    run_scan(1'b0, 1'b0);
    clr_at = -1;
    check_idle("cont_stop");
    hits = 0;
    repeat (60) begin
      @(negedge clock);
      if (trigger != '0) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL cont_no_trigger got %0d cycles want 0", hits);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int hits;
    randomize_scan();
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    for (int k = 0; k < 3; k++)
      run_channel(k, ws[k], ds[k], 1'b0, lat);
    run_channel(3, -1, 0, 1'b0, lat);
    repeat (2) @(negedge clock);
    echo[3] = 1'b1;
    repeat (40) @(negedge clock);
    total++;
    if (db_estado !== 4'd4 || canal !== 3'd3) begin
      bad++;
      $display("FAIL mid_state got st=%0d canal=%0d want st=4 canal=3",
               db_estado, canal);
    end
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset_async");
    echo = '0;
    @(negedge clock);
    reset = 1'b1;
    hits = 0;
    repeat (100) begin
      @(negedge clock);
      if (trigger != '0 || ocupado) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL post_reset_quiet got %0d busy cycles want 0", hits);
    end
    @(negedge clock);
    medir = 1'b1;
    @(negedge clock);
    medir = 1'b0;
    run_channel(0, 0, 0, 1'b0, lat);
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL post_reset_trig_latency got %0d want 2", lat);
    end
  endtask

  initial begin
    test_reset();
    test_single_scan();
    test_timeout();
    test_stale();
    test_continuous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
